uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLOCKS_PER_BIT, default 5208: clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 clk  input  1  system clock (50 MHz nominal).
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 i_valid  input  1  byte-offer strobe from the producer.
REQ-008 i_data  input  DATA_BITS  data to transmit; sampled on handshake.
REQ-009 o_ready  output  1  transmitter can accept a byte this cycle.
REQ-010 q  output  1  serial line; idle level 1.
REQ-011 o_active  output  1  frame in progress.
REQ-012 o_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-013 Handshake: a byte is accepted on a rising clk edge where i_valid=1 and o_ready=1; i_data is latched internally at that edge.
REQ-014 o_ready is 1 only in state IDLE; i_valid outside IDLE is ignored and i_data is not sampled.
REQ-015 States: IDLE, START, DATA, PARITY, STOP. Transitions are IDLE->START on accept, START->DATA, DATA->PARITY (PARITY!=0) or DATA->STOP (PARITY=0), PARITY->STOP, STOP->IDLE.
REQ-016 All outputs are registered; q, o_active and o_ready change one cycle after the causing edge.
REQ-017 Latency: q drops to 0 in the first cycle after the accept edge.
REQ-018 Each of the start, data, parity and stop bits holds q for exactly CLOCKS_PER_BIT cycles.
REQ-019 Data bits are sent LSB first, bit index 0..DATA_BITS-1.
REQ-020 Parity bit: even mode sends the XOR of the latched data; odd mode sends its inverse.
REQ-021 STOP drives q=1 for STOP_BITS*CLOCKS_PER_BIT cycles.
REQ-022 o_active is 1 from the first START cycle through the last STOP cycle, and 0 otherwise.
REQ-023 o_done pulses for exactly one cycle, in the cycle after the last STOP cycle, coinciding with o_ready returning to 1.
REQ-024 Back-to-back frames: a byte accepted in the first IDLE cycle starts its START bit on the next cycle, so minimum idle time between frames is 1 cycle.
REQ-025 Bit-time counter: width $clog2(CLOCKS_PER_BIT); resets to 0 at every bit boundary; never wraps mid-bit.
REQ-026 Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLOCKS_PER_BIT cycles.
REQ-027 The latched data register is unaffected by i_data changes after the accept edge.
REQ-028 An illegal state encoding returns to IDLE on the next edge with q=1.

Reset
REQ-029 While rst=1, immediately and independently of clk: q=1, o_active=0, o_done=0, o_ready=0, state=IDLE, counters=0, data register=0.
REQ-030 o_ready rises on the first clk edge after rst deasserts.
REQ-031 Reset asserted mid-frame aborts the frame; no o_done pulse is produced, and no partial frame resumes after reset.

Verification (CLOCKS_PER_BIT=4)
REQ-032 8N1, accept 0xA5 -> q = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; o_done pulses at cycle 41 after accept; o_active high for 40 cycles.
REQ-033 DATA_BITS=7, PARITY=2, accept 0x35 -> 7 data bits 1,0,1,0,1,1,0, then parity bit 0, then stop; frame length 40 cycles.
REQ-034 PARITY=1, STOP_BITS=2, accept 0x00 -> parity bit 1; q=1 for 8 cycles before o_done.
REQ-035 i_valid held high with 0x11 then 0x22 -> two frames; exactly 1 idle cycle (o_ready=1) between them; second frame carries 0x22.
REQ-036 rst pulsed during data bit 3 -> q=1 asynchronously, no o_done; after release, o_ready=1 and a subsequent 0x5A frame is correct.
REQ-037 i_valid=1 with i_data changing every cycle mid-frame -> transmitted frame equals the byte latched at accept; no extra accepts occur.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
//
// Configurable UART transmitter. A byte offered with i_valid is latched when
// o_ready is high. It is then shifted out on q as a frame: one start bit (0),
// DATA_BITS data bits LSB first, an optional parity bit, and STOP_BITS stop
// bits (1). Every bit lasts CLOCKS_PER_BIT clock cycles. All outputs are
// registered. Each one reflects the state the FSM enters on the same edge.
//
// Parameters
//   CLOCKS_PER_BIT  clk cycles per serial bit (2..65535)
//   DATA_BITS       data bits per frame (5..9)
//   PARITY          0 = none, 1 = odd, 2 = even
//   STOP_BITS       stop bits per frame (1 or 2)
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   i_valid   producer offers i_data this cycle
//   i_data    byte to transmit, latched on the accept edge
//   o_ready   transmitter is idle and will accept a byte this cycle
//   q         serial line, idles high
//   o_active  a frame is on the line
//   o_done    one-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int CLOCKS_PER_BIT = 5208,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 q,
  output logic                 o_active,
  output logic                 o_done
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bitIdx_q, bitIdx_d;
  logic                 stopIdx_q, stopIdx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 q_q, q_d;
  logic                 ready_q, ready_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 bitEnd;
  logic                 evenPar;

  // The bit timer has run its full CLOCKS_PER_BIT cycles for the current bit.
  assign bitEnd = (cnt_q == CNT_LAST);

  // State and output registers. Reset forces the line idle and holds
  // o_ready low. o_ready then rises on the first edge after reset is
  // released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bitIdx_q  <= '0;
      stopIdx_q <= 1'b0;
      data_q    <= '0;
      q_q       <= 1'b1;
      ready_q   <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitIdx_q  <= bitIdx_d;
      stopIdx_q <= stopIdx_d;
      data_q    <= data_d;
      q_q       <= q_d;
      ready_q   <= ready_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic. The bit timer restarts at every bit boundary. The data
  // index and stop index step only at those boundaries. Outputs are computed
  // from the next state so that the registered outputs line up with the
  // state register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitIdx_d  = bitIdx_q;
    stopIdx_d = stopIdx_q;
    data_d    = data_q;
    q_d       = 1'b1;
    ready_d   = 1'b0;
    active_d  = 1'b0;
    done_d    = 1'b0;
    evenPar   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bitIdx_d  = '0;
        stopIdx_d = 1'b0;
        // ready_q is the registered o_ready, so this is exactly the handshake
        // the producer observes.
        if (i_valid && ready_q) begin
          data_d  = i_data;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bitEnd) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bitEnd) begin
          cnt_d = '0;
          if (bitIdx_q == IDX_LAST) begin
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bitIdx_d = bitIdx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (bitEnd) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bitEnd) begin
          cnt_d = '0;
          if (stopIdx_q == STOP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            stopIdx_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // Unused encodings recover to an idle line on the next edge.
        state_d   = ST_IDLE;
        cnt_d     = '0;
        bitIdx_d  = '0;
        stopIdx_d = 1'b0;
      end
    endcase

    evenPar = ^data_d;
    case (state_d)
      ST_START:  q_d = 1'b0;
      ST_DATA:   q_d = data_d[bitIdx_d];
      ST_PARITY: q_d = (PARITY == 1) ? ~evenPar : evenPar;
      default:   q_d = 1'b1;
    endcase

    active_d = (state_d == ST_START) || (state_d == ST_DATA) ||
               (state_d == ST_PARITY) || (state_d == ST_STOP);
    ready_d  = (state_d == ST_IDLE);
    done_d   = (state_q == ST_STOP) && (state_d == ST_IDLE);
  end

  assign q        = q_q;
  assign o_ready  = ready_q;
  assign o_active = active_q;
  assign o_done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg
//
// Three transmitters share one clock and one reset: 8N1, 7E1 and 8O2. Every
// bit lasts 4 clocks. Each frame's expected line levels come from a list of
// frame bits: start, the data bits LSB first, parity if enabled, then the
// stop bits. Every cycle of the frame is compared with that list, and so is
// the completion cycle that follows. While a frame is in flight, i_data and
// i_valid are scrambled to show that nothing extra is accepted.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

  localparam int CPB = 4;
  localparam int NI  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] validV;
  logic [7:0]    dataIn [NI];
  logic [NI-1:0] readyV;
  logic [NI-1:0] qV;
  logic [NI-1:0] activeV;
  logic [NI-1:0] doneV;

  int testsRun  = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8n1 (
    .clk(clk), .rst(rst), .i_valid(validV[0]), .i_data(dataIn[0]),
    .o_ready(readyV[0]), .q(qV[0]), .o_active(activeV[0]), .o_done(doneV[0]));

  uart_tx_cfg #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut7e1 (
    .clk(clk), .rst(rst), .i_valid(validV[1]), .i_data(dataIn[1][6:0]),
    .o_ready(readyV[1]), .q(qV[1]), .o_active(activeV[1]), .o_done(doneV[1]));

  uart_tx_cfg #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut8o2 (
    .clk(clk), .rst(rst), .i_valid(validV[2]), .i_data(dataIn[2]),
    .o_ready(readyV[2]), .q(qV[2]), .o_active(activeV[2]), .o_done(doneV[2]));

  // Frame format of each instance.
  function automatic int dataBitsOf(int inst);
    return (inst == 1) ? 7 : 8;
  endfunction

  function automatic int parityOf(int inst);
    case (inst)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stopBitsOf(int inst);
    return (inst == 2) ? 2 : 1;
  endfunction

  function automatic int frameBits(int inst);
    return 1 + dataBitsOf(inst) + ((parityOf(inst) != 0) ? 1 : 0) + stopBitsOf(inst);
  endfunction

  // Line level for frame bit number pos of value.
  function automatic logic expectedBit(int inst, logic [7:0] value, int pos);
    int db   = dataBitsOf(inst);
    int ones = 0;
    if (pos == 0) return 1'b0;
    if (pos <= db) return value[pos-1];
    for (int i = 0; i < db; i++) ones += int'(value[i]);
    if (parityOf(inst) != 0 && pos == db + 1) begin
      if (parityOf(inst) == 2) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  // Records one comparison and prints a line if it mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Idle-line checks on every instance for n cycles.
  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        checkOutput($sformatf("inst%0d idle ready", i), readyV[i], 1);
        checkOutput($sformatf("inst%0d idle q", i), qV[i], 1);
        checkOutput($sformatf("inst%0d idle active", i), activeV[i], 0);
        checkOutput($sformatf("inst%0d idle done", i), doneV[i], 0);
      end
    end
  endtask

  // Offers value at the current negedge, where o_ready must already be high.
  // Then follows the whole frame and the done cycle. The call returns at the
  // done cycle with i_valid low, so an immediate next call is back-to-back.
  task automatic applyStimulus(input int inst, input logic [7:0] value, input bit holdValid);
    int len = frameBits(inst) * CPB;
    checkOutput($sformatf("inst%0d ready before accept", inst), readyV[inst], 1);
    validV[inst] = 1'b1;
    dataIn[inst] = value;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      checkOutput($sformatf("inst%0d val %0h cyc%0d q", inst, value, c), qV[inst],
                  expectedBit(inst, value, (c - 1) / CPB));
      checkOutput($sformatf("inst%0d cyc%0d active", inst, c), activeV[inst], 1);
      checkOutput($sformatf("inst%0d cyc%0d ready", inst, c), readyV[inst], 0);
      checkOutput($sformatf("inst%0d cyc%0d done", inst, c), doneV[inst], 0);
      dataIn[inst] = 8'($urandom);
      validV[inst] = holdValid ? 1'b1 : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    checkOutput($sformatf("inst%0d end done", inst), doneV[inst], 1);
    checkOutput($sformatf("inst%0d end ready", inst), readyV[inst], 1);
    checkOutput($sformatf("inst%0d end active", inst), activeV[inst], 0);
    checkOutput($sformatf("inst%0d end q", inst), qV[inst], 1);
    validV[inst] = 1'b0;
  endtask

  // Asynchronous reset values, checked between clock edges.
  task automatic checkResetOutputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("%s inst%0d q", tag, i), qV[i], 1);
      checkOutput($sformatf("%s inst%0d active", tag, i), activeV[i], 0);
      checkOutput($sformatf("%s inst%0d ready", tag, i), readyV[i], 0);
      checkOutput($sformatf("%s inst%0d done", tag, i), doneV[i], 0);
    end
  endtask

  // Releases reset at a negedge. o_ready must be up one edge later.
  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++)
      checkOutput($sformatf("inst%0d ready after reset", i), readyV[i], 1);
  endtask

  initial begin
    rst    = 1'b1;
    validV = '0;
    for (int i = 0; i < NI; i++) dataIn[i] = 8'h00;
    #1;
    checkResetOutputs("reset t1");
    repeat (3) @(negedge clk);
    checkResetOutputs("reset held");
    releaseReset();

    // Directed frames from the frame-format examples.
    applyStimulus(0, 8'hA5, 1'b0);
    idleCycles(2);
    applyStimulus(1, 8'h35, 1'b0);
    idleCycles(1);
    applyStimulus(2, 8'h00, 1'b0);
    idleCycles(1);

    // Valid held high: the second byte follows after a single ready cycle.
    applyStimulus(0, 8'h11, 1'b1);
    applyStimulus(0, 8'h22, 1'b1);
    idleCycles(1);

    // Data churning under a held valid must not disturb the latched byte.
    applyStimulus(1, 8'($urandom), 1'b1);
    idleCycles(1);

    // Reset during data bit 3 aborts the frame with no done pulse.
    validV[0] = 1'b1;
    dataIn[0] = 8'hC3;
    repeat (CPB * 4 + 2) begin
      @(negedge clk);
      dataIn[0] = 8'($urandom);
    end
    #2 rst = 1'b1;
    #1;
    checkResetOutputs("abort");
    validV[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkResetOutputs("abort held");
    end
    releaseReset();
    idleCycles(4);
    applyStimulus(0, 8'h5A, 1'b0);
    idleCycles(1);

    // Randomized frames across all instances with random gaps.
    for (int n = 0; n < 30; n++) begin
      int inst = int'($urandom_range(0, NI - 1));
      applyStimulus(inst, 8'($urandom), 1'($urandom_range(0, 1)));
      idleCycles(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, %0d tests run, %0d failed",
             testsRun, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
